ball_engine: RTL and testbench

Downstream consumer of the paddle_movement stage in the Pong datapath. Takes both paddle Y positions and advances the ball once per frame tick. Handles bounces off the top and bottom walls and off the paddles, and detects misses. Drives ball coordinates to the renderer, point pulses to the scoreboard, and reset_game back to paddle_movement after each point.

---
 rtl/ball_engine_if.sv | 27 ++
 rtl/ball_engine.sv | 203 ++++++++++++++++++++
 tb/tb_ball_engine.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/ball_engine_if.sv
// Pong ball engine interface: frame tick, serve and paddle positions in;
// ball position, point pulses, reset_game and FSM state out.
interface ball_engine_if #(
  parameter int X_W = 10,
  parameter int Y_W = 10
);
  logic           tick;
  logic           serve;
  logic [Y_W-1:0] p1y;
  logic [Y_W-1:0] p2y;
  logic [X_W-1:0] ball_x;
  logic [Y_W-1:0] ball_y;
  logic           p1_point;
  logic           p2_point;
  logic           reset_game;
  logic [1:0]     state;

  modport master (
    output tick, serve, p1y, p2y,
    input  ball_x, ball_y, p1_point, p2_point, reset_game, state
  );

  modport slave (
    input  tick, serve, p1y, p2y,
    output ball_x, ball_y, p1_point, p2_point, reset_game, state
  );
endinterface

// File: rtl/ball_engine.sv
// Pong ball engine: advances the ball once per frame tick, bounces it off
// walls and paddles, detects misses and holds the ball after each point.
// Optional build macro SPEEDUP_EN: each paddle hit raises the per-axis step
// by one, saturating at MAX_SPEED; the step reloads to SPEED on every serve.
module ball_engine #(
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int X_W        = 10,
  parameter int Y_W        = 10,
  parameter int BALL_SIZE  = 8,
  parameter int PADDLE_H   = 64,
  parameter int P1_X       = 16,
  parameter int P2_X       = 616,
  parameter int SPEED      = 2,
  parameter int HOLD_TICKS = 60,
  parameter int MAX_SPEED  = 6
) (
  input  logic         clk,
  input  logic         reset,
  ball_engine_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, MOVE = 2'd1, SCORED = 2'd2} state_t;

  localparam int SP_MAX = (MAX_SPEED > SPEED) ? MAX_SPEED : SPEED;
  localparam int SP_W   = $clog2(SP_MAX + 1);
  localparam int HC_W   = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  localparam logic [X_W-1:0] X_CTR  = X_W'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [Y_W-1:0] Y_CTR  = Y_W'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [X_W:0]   XE_P1  = (X_W+1)'(P1_X);
  localparam logic [X_W:0]   XE_P2  = (X_W+1)'(P2_X);
  localparam logic [X_W:0]   XE_B   = (X_W+1)'(BALL_SIZE);
  localparam logic [X_W:0]   XE_RW  = (X_W+1)'(SCREEN_W - BALL_SIZE);
  localparam logic [Y_W:0]   YE_B   = (Y_W+1)'(BALL_SIZE);
  localparam logic [Y_W:0]   YE_PH  = (Y_W+1)'(PADDLE_H);
  localparam logic [Y_W:0]   YE_BOT = (Y_W+1)'(SCREEN_H - BALL_SIZE);

  state_t          state_q, state_d;
  logic [X_W-1:0]  bx_q, bx_d;
  logic [Y_W-1:0]  by_q, by_d;
  logic            dirx_q, dirx_d;   // 1 = right
  logic            diry_q, diry_d;   // 1 = down
  logic [HC_W-1:0] hold_q, hold_d;
  logic            p1pt_q, p1pt_d;
  logic            p2pt_q, p2pt_d;
  logic            rg_q, rg_d;
  logic [SP_W-1:0] step;

`ifdef SPEEDUP_EN
  logic [SP_W-1:0] speed_q, speed_d;
  assign step = speed_q;
`else
  assign step = SP_W'(SPEED);
`endif

  // Widened operands so sums and differences never wrap.
  logic [X_W:0] xe, sx;
  logic [Y_W:0] ye, sy, p1e, p2e;
  logic         ov1, ov2, cross_l, cross_r;

  assign xe  = {1'b0, bx_q};
  assign ye  = {1'b0, by_q};
  assign sx  = (X_W+1)'(step);
  assign sy  = (Y_W+1)'(step);
  assign p1e = {1'b0, bus.p1y};
  assign p2e = {1'b0, bus.p2y};

  // Paddle overlap uses the pre-update ball_y; crossing means the move
  // would reach or pass the paddle's inner face from the field side.
  assign ov1     = (ye + YE_B > p1e) && (ye < p1e + YE_PH);
  assign ov2     = (ye + YE_B > p2e) && (ye < p2e + YE_PH);
  assign cross_l = (xe >= XE_P1) && (xe - sx <= XE_P1);
  assign cross_r = (xe + XE_B <= XE_P2) && (xe + XE_B + sx >= XE_P2);

  // Next-state logic: serve, per-tick motion, scoring and hold countdown.
  always_comb begin
    state_d = state_q;
    bx_d    = bx_q;
    by_d    = by_q;
    dirx_d  = dirx_q;
    diry_d  = diry_q;
    hold_d  = hold_q;
    p1pt_d  = 1'b0;
    p2pt_d  = 1'b0;
    rg_d    = 1'b0;
`ifdef SPEEDUP_EN
    speed_d = speed_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.serve) begin
          state_d = MOVE;
`ifdef SPEEDUP_EN
          speed_d = SP_W'(SPEED);
`endif
        end
      end
      MOVE: begin
        if (bus.tick) begin
          if (diry_q) begin
            if (ye + sy >= YE_BOT) begin
              by_d   = Y_W'(YE_BOT);
              diry_d = 1'b0;
            end else begin
              by_d = Y_W'(ye + sy);
            end
          end else begin
            if (ye <= sy) begin
              by_d   = '0;
              diry_d = 1'b1;
            end else begin
              by_d = Y_W'(ye - sy);
            end
          end
          if (!dirx_q) begin
            if (cross_l && ov1) begin
              bx_d   = X_W'(XE_P1);
              dirx_d = 1'b1;
`ifdef SPEEDUP_EN
              if (speed_q < SP_W'(MAX_SPEED)) speed_d = speed_q + SP_W'(1);
`endif
            end else if (xe <= sx) begin
              bx_d    = '0;
              p2pt_d  = 1'b1;
              state_d = SCORED;
            end else begin
              bx_d = X_W'(xe - sx);
            end
          end else begin
            if (cross_r && ov2) begin
              bx_d   = X_W'(XE_P2 - XE_B);
              dirx_d = 1'b0;
`ifdef SPEEDUP_EN
              if (speed_q < SP_W'(MAX_SPEED)) speed_d = speed_q + SP_W'(1);
`endif
            end else if (xe + sx >= XE_RW) begin
              bx_d    = X_W'(XE_RW);
              p1pt_d  = 1'b1;
              state_d = SCORED;
            end else begin
              bx_d = X_W'(xe + sx);
            end
          end
        end
      end
      SCORED: begin
        if (bus.tick) begin
          if (hold_q == HC_W'(HOLD_TICKS - 1)) begin
            rg_d    = 1'b1;
            hold_d  = '0;
            bx_d    = X_CTR;
            by_d    = Y_CTR;
            diry_d  = 1'b1;
            state_d = IDLE;
          end else begin
            hold_d = hold_q + HC_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      bx_q    <= X_CTR;
      by_q    <= Y_CTR;
      dirx_q  <= 1'b1;
      diry_q  <= 1'b1;
      hold_q  <= '0;
      p1pt_q  <= 1'b0;
      p2pt_q  <= 1'b0;
      rg_q    <= 1'b0;
`ifdef SPEEDUP_EN
      speed_q <= SP_W'(SPEED);
`endif
    end else begin
      state_q <= state_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      dirx_q  <= dirx_d;
      diry_q  <= diry_d;
      hold_q  <= hold_d;
      p1pt_q  <= p1pt_d;
      p2pt_q  <= p2pt_d;
      rg_q    <= rg_d;
`ifdef SPEEDUP_EN
      speed_q <= speed_d;
`endif
    end
  end

  assign bus.ball_x     = bx_q;
  assign bus.ball_y     = by_q;
  assign bus.p1_point   = p1pt_q;
  assign bus.p2_point   = p2pt_q;
  assign bus.reset_game = rg_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_ball_engine.sv
// Self-checking bench for ball_engine: randomized ticks, serves and paddle
// positions checked every cycle against an integer model of the ball rules.
module tb_ball_engine;

  localparam int SCREEN_W   = 640;
  localparam int SCREEN_H   = 480;
  localparam int X_W        = 10;
  localparam int Y_W        = 10;
  localparam int BALL_SIZE  = 8;
  localparam int PADDLE_H   = 64;
  localparam int P1_X       = 16;
  localparam int P2_X       = 616;
  localparam int SPEED      = 2;
  localparam int HOLD_TICKS = 4;
  localparam int MAX_SPEED  = 6;

  logic clk;
  logic reset;

  ball_engine_if #(.X_W(X_W), .Y_W(Y_W)) bus ();

  ball_engine #(
    .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .X_W(X_W), .Y_W(Y_W),
    .BALL_SIZE(BALL_SIZE), .PADDLE_H(PADDLE_H), .P1_X(P1_X), .P2_X(P2_X),
    .SPEED(SPEED), .HOLD_TICKS(HOLD_TICKS), .MAX_SPEED(MAX_SPEED)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: positions as plain ints, directions as +1/-1, state 0/1/2.
  int mx, my, mdx, mdy, mst, mhold, mspd;
  bit mp1, mp2, mrg;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mx = (SCREEN_W - BALL_SIZE) / 2;
    my = (SCREEN_H - BALL_SIZE) / 2;
    mdx = 1; mdy = 1; mst = 0; mhold = 0; mspd = SPEED;
    mp1 = 0; mp2 = 0; mrg = 0;
  endtask

  task automatic bump_speed();
`ifdef SPEEDUP_EN
    if (mspd < MAX_SPEED) mspd++;
`endif
  endtask

  task automatic model_step(input bit t, input bit s, input int p1, input int p2);
    int oy;
    mp1 = 0; mp2 = 0; mrg = 0;
    if (mst == 0) begin
      if (s) begin
        mst = 1;
        mspd = SPEED;
      end
    end else if (mst == 1) begin
      if (t) begin
        oy = my;
        // Vertical motion with wall clamp.
        if (mdy > 0) begin
          if (my + mspd >= SCREEN_H - BALL_SIZE) begin my = SCREEN_H - BALL_SIZE; mdy = -1; end
          else my = my + mspd;
        end else begin
          if (my <= mspd) begin my = 0; mdy = 1; end
          else my = my - mspd;
        end
        // Horizontal motion with paddle and goal handling.
        if (mdx < 0) begin
          if (mx >= P1_X && mx - mspd <= P1_X && oy + BALL_SIZE > p1 && oy < p1 + PADDLE_H) begin
            mx = P1_X; mdx = 1; bump_speed();
          end else if (mx <= mspd) begin
            mx = 0; mp2 = 1; mst = 2;
          end else mx = mx - mspd;
        end else begin
          if (mx + BALL_SIZE <= P2_X && mx + BALL_SIZE + mspd >= P2_X &&
              oy + BALL_SIZE > p2 && oy < p2 + PADDLE_H) begin
            mx = P2_X - BALL_SIZE; mdx = -1; bump_speed();
          end else if (mx + mspd >= SCREEN_W - BALL_SIZE) begin
            mx = SCREEN_W - BALL_SIZE; mp1 = 1; mst = 2;
          end else mx = mx + mspd;
        end
      end
    end else begin
      if (t) begin
        mhold++;
        if (mhold == HOLD_TICKS) begin
          mrg = 1; mhold = 0;
          mx = (SCREEN_W - BALL_SIZE) / 2;
          my = (SCREEN_H - BALL_SIZE) / 2;
          mdy = 1; mst = 0;
        end
      end
    end
  endtask

  // Model advances on the same edges as the DUT.
  always @(posedge clk or negedge reset) begin
    if (!reset) model_reset();
    else model_step(bus.tick, bus.serve, int'(bus.p1y), int'(bus.p2y));
  end

  // Every-cycle comparison against the model, plus literal pins on events.
  always @(negedge clk) begin
    if (reset) begin
      chk("ball_x", int'(bus.ball_x), mx);
      chk("ball_y", int'(bus.ball_y), my);
      chk("state", int'(bus.state), mst);
      chk("p1_point", int'(bus.p1_point), int'(mp1));
      chk("p2_point", int'(bus.p2_point), int'(mp2));
      chk("reset_game", int'(bus.reset_game), int'(mrg));
      if (mp1) chk("p1_point_at_wall", int'(bus.ball_x), 632);
      if (mp2) chk("p2_point_at_wall", int'(bus.ball_x), 0);
      if (mrg) begin
        chk("recentre_x", int'(bus.ball_x), 316);
        chk("recentre_y", int'(bus.ball_y), 236);
        chk("idle_after_hold", int'(bus.state), 0);
      end
    end
  end

  task automatic cyc(input bit t, input bit s);
    bus.tick  = t;
    bus.serve = s;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [Y_W-1:0] pick_paddle(input int y);
    int p;
    if ($urandom_range(0, 3) != 0) p = y + 4 - int'($urandom_range(0, 66));
    else p = int'($urandom_range(0, SCREEN_H - PADDLE_H));
    if (p < 0) p = 0;
    if (p > SCREEN_H - 1) p = SCREEN_H - 1;
    return Y_W'(p);
  endfunction

  initial begin
    reset = 1'b0;
    bus.tick = 1'b0;
    bus.serve = 1'b0;
    bus.p1y = Y_W'(200);
    bus.p2y = Y_W'(200);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Ticks in IDLE leave the ball centred.
    repeat (5) cyc(1'b1, 1'b0);
    @(negedge clk);
    chk("idle_x", int'(bus.ball_x), 316);
    chk("idle_y", int'(bus.ball_y), 236);
    chk("idle_state", int'(bus.state), 0);
    @(posedge clk); #1;

    // Serve, then ten ticks of motion right/down.
    cyc(1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
    end
    @(negedge clk);
    chk("serve_state", int'(bus.state), 1);
    chk("serve_x", int'(bus.ball_x), 336);
    chk("serve_y", int'(bus.ball_y), 256);
    @(posedge clk); #1;

    // Randomized play: paddles mostly track the ball so hits and misses mix.
    for (int i = 0; i < 20000; i++) begin
      bus.p1y = pick_paddle(my);
      bus.p2y = pick_paddle(my);
      cyc($urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
    end

    // Get back into MOVE, then assert reset between clock edges.
    for (int k = 0; k < 400 && mst != 1; k++) cyc(k[0], 1'b1);
    chk("reached_move", mst, 1);
    repeat (3) cyc(1'b1, 1'b0);
    #3 reset = 1'b0;
    #1;
    chk("async_rst_x", int'(bus.ball_x), 316);
    chk("async_rst_y", int'(bus.ball_y), 236);
    chk("async_rst_state", int'(bus.state), 0);
    chk("async_rst_p1", int'(bus.p1_point), 0);
    chk("async_rst_p2", int'(bus.p2_point), 0);
    chk("async_rst_rg", int'(bus.reset_game), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (4) cyc(1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
